// File: rtl/ixu_mp_dispatch.sv
// Dispatch feeder for the integer issue queue: compacts a two-wide rename bundle into a
// one-bundle staging register and owns the physical-register ready scoreboard.
module ixu_mp_dispatch #(
    parameter int PRF_TAGS = 64
) (
    input  logic        core_clock_i,
    input  logic        core_reset_n_i,
    input  logic        core_flush_i,

    input  logic        ren0_vld_i,
    input  logic        ren1_vld_i,
    input  logic [17:0] ren0_data_i,
    input  logic [17:0] ren1_data_i,
    input  logic        ren0_rs1_vld_i,
    input  logic        ren0_rs2_vld_i,
    input  logic        ren1_rs1_vld_i,
    input  logic        ren1_rs2_vld_i,
    input  logic        ren0_rd_vld_i,
    input  logic        ren1_rd_vld_i,
    input  logic [5:0]  ren0_rd_i,
    input  logic [5:0]  ren1_rd_i,
    input  logic        ren0_sc_only_i,
    input  logic        ren0_mc_only_i,
    input  logic        ren1_sc_only_i,
    input  logic        ren1_mc_only_i,
    output logic        ren_busy_o,

    output logic [17:0] p0_data_o,
    output logic [17:0] p1_data_o,
    output logic        p0_vld_o,
    output logic        p1_vld_o,
    output logic        p0_rs1_vld_o,
    output logic        p0_rs2_vld_o,
    output logic        p1_rs1_vld_o,
    output logic        p1_rs2_vld_o,
    output logic        p0_rs1_rdy,
    output logic        p0_rs2_rdy,
    output logic        p1_rs1_rdy,
    output logic        p1_rs2_rdy,
    output logic        p0_restrict_to_sc_o,
    output logic        p0_restrict_to_mc_o,
    output logic        p1_restrict_to_sc_o,
    output logic        p1_restrict_to_mc_o,
    input  logic        p0_busy_i,
    input  logic        p1_busy_i,

    input  logic [5:0]  eu0_wk,
    input  logic [5:0]  eu1_wk,
    input  logic [5:0]  eu2_wk,
    input  logic [5:0]  eu3_wk,
    input  logic        eu0_vld,
    input  logic        eu1_vld,
    input  logic        eu2_vld,
    input  logic        eu3_vld
);

    typedef struct packed {
        logic [17:0] data;
        logic        rs1_vld;
        logic        rs2_vld;
        logic        sc_only;
        logic        mc_only;
    } slot_t;

    logic                held_vld_q, held_vld_d;
    logic                held_two_q, held_two_d;
    slot_t               slot0_q, slot0_d;
    slot_t               slot1_q, slot1_d;
    logic [PRF_TAGS-1:0] sb_q, sb_d;

    logic  go;
    logic  capture;
    slot_t ren0_slot;
    slot_t ren1_slot;

    assign go         = held_vld_q && (held_two_q ? !p1_busy_i : !p0_busy_i);
    assign ren_busy_o = held_vld_q && !go;
    assign capture    = !ren_busy_o && !core_flush_i && (ren0_vld_i || ren1_vld_i);

    assign ren0_slot = '{data: ren0_data_i, rs1_vld: ren0_rs1_vld_i, rs2_vld: ren0_rs2_vld_i,
                         sc_only: ren0_sc_only_i, mc_only: ren0_mc_only_i};
    assign ren1_slot = '{data: ren1_data_i, rs1_vld: ren1_rs1_vld_i, rs2_vld: ren1_rs2_vld_i,
                         sc_only: ren1_sc_only_i, mc_only: ren1_mc_only_i};

    always_comb begin
        held_vld_d = held_vld_q;
        held_two_d = held_two_q;
        slot0_d    = slot0_q;
        slot1_d    = slot1_q;

        if (go) begin
            held_vld_d = 1'b0;
        end
        if (capture) begin
            held_vld_d = 1'b1;
            // A lone ren1 op is compacted into slot 0 so it only needs one queue entry.
            if (ren0_vld_i) begin
                slot0_d    = ren0_slot;
                slot1_d    = ren1_slot;
                held_two_d = ren1_vld_i;
            end else begin
                slot0_d    = ren1_slot;
                held_two_d = 1'b0;
            end
        end
        if (core_flush_i) begin
            held_vld_d = 1'b0;
        end
    end

    always_comb begin
        sb_d = sb_q;
        if (eu0_vld) sb_d[eu0_wk] = 1'b1;
        if (eu1_vld) sb_d[eu1_wk] = 1'b1;
        if (eu2_vld) sb_d[eu2_wk] = 1'b1;
        if (eu3_vld) sb_d[eu3_wk] = 1'b1;
        // Clears are applied after wakeups so a newly allocated tag wins over a stale writeback.
        if (capture && ren0_vld_i && ren0_rd_vld_i) sb_d[ren0_rd_i] = 1'b0;
        if (capture && ren1_vld_i && ren1_rd_vld_i) sb_d[ren1_rd_i] = 1'b0;
        if (core_flush_i) sb_d = '1;
        sb_d[0] = 1'b1;
    end

    always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            held_vld_q <= 1'b0;
            held_two_q <= 1'b0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            sb_q       <= '1;
        end else begin
            held_vld_q <= held_vld_d;
            held_two_q <= held_two_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            sb_q       <= sb_d;
        end
    end

    assign p0_vld_o            = go;
    assign p1_vld_o            = go && held_two_q;
    assign p0_data_o           = slot0_q.data;
    assign p1_data_o           = slot1_q.data;
    assign p0_rs1_vld_o        = slot0_q.rs1_vld;
    assign p0_rs2_vld_o        = slot0_q.rs2_vld;
    assign p1_rs1_vld_o        = slot1_q.rs1_vld;
    assign p1_rs2_vld_o        = slot1_q.rs2_vld;
    assign p0_restrict_to_sc_o = slot0_q.sc_only;
    assign p0_restrict_to_mc_o = slot0_q.mc_only;
    assign p1_restrict_to_sc_o = slot1_q.sc_only;
    assign p1_restrict_to_mc_o = slot1_q.mc_only;

    assign p0_rs1_rdy = sb_q[slot0_q.data[17:12]];
    assign p0_rs2_rdy = sb_q[slot0_q.data[11:6]];
    assign p1_rs1_rdy = sb_q[slot1_q.data[17:12]];
    assign p1_rs2_rdy = sb_q[slot1_q.data[11:6]];

endmodule
